// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered
// sync, data-enable and line/frame strobes for the video path.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int x_width  =
    $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int y_width  =
    $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [x_width-1:0] sx,
  output logic [y_width-1:0] sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [x_width-1:0] X_MAX =
    x_width'(H_TOTAL - 1);
  localparam logic [y_width-1:0] Y_MAX =
    y_width'(V_TOTAL - 1);
  localparam logic [x_width-1:0] X_ACT =
    x_width'(H_ACTIVE);
  localparam logic [y_width-1:0] Y_ACT =
    y_width'(V_ACTIVE);

  // Sync windows held as inclusive [first, last] so the
  // bounds always fit the counter width, even with no back porch.
  localparam logic [x_width-1:0] HS_FIRST =
    x_width'(H_ACTIVE + H_FP);
  localparam logic [x_width-1:0] HS_LAST =
    x_width'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [y_width-1:0] VS_FIRST =
    y_width'(V_ACTIVE + V_FP);
  localparam logic [y_width-1:0] VS_LAST =
    y_width'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [x_width-1:0] sx_nxt;
  logic [y_width-1:0] sy_nxt;
  logic               hs_act;
  logic               vs_act;
  logic               de_nxt;
  logic               ls_nxt;
  logic               fs_nxt;

  // Next raster position and the decode of that position, so the
  // registered flags line up with the registered counters.
  always_comb begin
    sx_nxt = sx + 1'b1;
    sy_nxt = sy;
    if (sx == X_MAX) begin
      sx_nxt = '0;
      if (sy == Y_MAX) begin
        sy_nxt = '0;
      end else begin
        sy_nxt = sy + 1'b1;
      end
    end
    hs_act = (sx_nxt >= HS_FIRST) && (sx_nxt <= HS_LAST);
    vs_act = (sy_nxt >= VS_FIRST) && (sy_nxt <= VS_LAST);
    de_nxt = (sx_nxt < X_ACT) && (sy_nxt < Y_ACT);
    ls_nxt = (sx_nxt == '0);
    fs_nxt = (sx_nxt == '0) && (sy_nxt == '0);
  end

  // Reset parks on the last pixel of the frame; ce gates every update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= X_MAX;
      sy          <= Y_MAX;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      sx          <= sx_nxt;
      sy          <= sy_nxt;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1080p instance plus a tiny
// inverted-polarity instance, both checked against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  logic [11:0] sx0;
  logic [10:0] sy0;
  logic        hs0, vs0, de0, ls0, fs0;

  logic [3:0]  sx1;
  logic [2:0]  sy1;
  logic        hs1, vs1, de1, ls1, fs1;

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .sx          (sx0),
    .sy          (sy0),
    .hsync       (hs0),
    .vsync       (vs0),
    .de          (de0),
    .line_start  (ls0),
    .frame_start (fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .sx          (sx1),
    .sy          (sy1),
    .hsync       (hs1),
    .vsync       (vs1),
    .de          (de1),
    .line_start  (ls1),
    .frame_start (fs1)
  );

  int checks = 0;
  int errors = 0;
  // ce-qualified edges since the last reset release
  int n = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s n=%0d got %0d exp %0d t=%0t",
                 tag, n, got, exp, $time);
    end
  endtask

  // Reset sits one pixel before frame start, so after nn edges the
  // raster index is (nn - 1) mod frame size.
  task automatic exp_px(input int nn,
                        input int ha, hf, hs, hb,
                        input int va, vf, vs, vb,
                        output int ex, ey, eh, ev,
                        output int ede, els, efs);
    int ht, vt, fr, l;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    fr  = ht * vt;
    l   = (nn + fr - 1) % fr;
    ex  = l % ht;
    ey  = l / ht;
    eh  = int'(ex >= ha + hf && ex < ha + hf + hs);
    ev  = int'(ey >= va + vf && ey < va + vf + vs);
    ede = int'(ex < ha && ey < va);
    els = int'(nn > 0 && ex == 0);
    efs = int'(nn > 0 && ex == 0 && ey == 0);
  endtask

  task automatic check_all();
    int ex, ey, eh, ev, ede, els, efs;
    exp_px(n, 1920, 88, 44, 148, 1080, 4, 5, 36,
           ex, ey, eh, ev, ede, els, efs);
    chk("sx", 32'(sx0), 32'(ex));
    chk("sy", 32'(sy0), 32'(ey));
    chk("hsync", 32'(hs0), 32'(eh));
    chk("vsync", 32'(vs0), 32'(ev));
    chk("de", 32'(de0), 32'(ede));
    chk("line_start", 32'(ls0), 32'(els));
    chk("frame_start", 32'(fs0), 32'(efs));
    exp_px(n, 8, 2, 2, 2, 4, 1, 1, 1,
           ex, ey, eh, ev, ede, els, efs);
    chk("s_sx", 32'(sx1), 32'(ex));
    chk("s_sy", 32'(sy1), 32'(ey));
    chk("s_hsync", 32'(hs1), 32'(1 - eh));
    chk("s_vsync", 32'(vs1), 32'(1 - ev));
    chk("s_de", 32'(de1), 32'(ede));
    chk("s_line_start", 32'(ls1), 32'(els));
    chk("s_frame_start", 32'(fs1), 32'(efs));
  endtask

  // Check on the falling edge, then drive ce/rst_n for the next edge.
  task automatic cyc(input bit c, input bit r);
    @(negedge clk);
    check_all();
    rst_n = r;
    ce    = c;
    if (!r) n = 0;
    else if (c) n++;
  endtask

  initial begin
    rst_n = 1'b1;
    ce    = 1'b0;
    #2 rst_n = 1'b0;

    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (4450) cyc(1'b1, 1'b1);

    for (int i = 0; i < 6700; i++)
      cyc(i % 3 == 0, 1'b1);

    repeat (2000)
      cyc(($urandom_range(0, 2) == 0), 1'b1);

    while (((n + 2475000 - 1) % 2200) != 1000 || n < 2200)
      cyc(1'b1, 1'b1);

    @(negedge clk);
    check_all();
    chk("mid_sx", 32'(sx0), 32'd1000);
    #1 rst_n = 1'b0;
    ce = 1'b1;
    n  = 0;
    #1 check_all();
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (2300) cyc(1'b1, 1'b1);

    @(negedge clk);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
